// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared widths and layer ids for the VGA display pipeline
// Contents:
//   ROM_ADDR_W  image-ROM address width
//   PIX_W       pixel width (RGB444)
//   LAYER_*     requester ids of the display layers on the shared ROM port
//   WAIT_W      width of the per-requester starvation counters (MAX_WAIT up to 15)
package display_pkg;

    localparam int ROM_ADDR_W  = 19;
    localparam int PIX_W       = 12;

    localparam int LAYER_BG    = 0;
    localparam int LAYER_FRUIT = 1;
    localparam int LAYER_BLADE = 2;
    localparam int LAYER_HUD   = 3;

    localparam int WAIT_W      = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
// Ports:
//   req  in   NUM_REQ   asserted request bits
//   ptr  in   ID_W      index searched first; search wraps at NUM_REQ
//   gnt  out  NUM_REQ   one-hot grant, zero when req is zero
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [ID_W:0]   idx_w;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx_w = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap keeps the search inside 0..NUM_REQ-1 even when
            // NUM_REQ is not a power of two.
            idx_w = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            end
            idx = idx_w[ID_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the image-ROM read port between display layers
// Ports:
//   clk        in   1                 pixel/system clock
//   rst        in   1                 synchronous reset, active high
//   req        in   NUM_REQ           per-requester read request (level)
//   req_addr   in   NUM_REQ*ADDR_W    flat addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt        out  NUM_REQ           one-hot grant, same cycle as req
//   mem_addr   out  ADDR_W            registered ROM address
//   mem_data   in   DATA_W            ROM read data
//   rsp_valid  out  1                 response valid
//   rsp_id     out  ID_W              requester id of the response
//   rsp_data   out  DATA_W            pixel data, 0 when rsp_valid is low
module rom_port_arbiter
    import display_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int ADDR_W   = ROM_ADDR_W,
    parameter  int DATA_W   = PIX_W,
    parameter  int ROM_LAT  = 1,
    parameter  int PRIO0    = 1,
    parameter  int MAX_WAIT = 7,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [ID_W-1:0]    ptr;
    logic [WAIT_W-1:0]  wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] forced;
    logic [NUM_REQ-1:0] forced_gnt;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [ADDR_W-1:0]  sel_addr;

    // Tag pipeline: stage 0 lines up with mem_addr, stage ROM_LAT with mem_data.
    logic [ROM_LAT:0]   tag_v;
    logic [ID_W-1:0]    tag_id [ROM_LAT+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        forced = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            forced[i] = req[i] && (wait_cnt[i] == WAIT_W'(MAX_WAIT));
        end
    end

    // Isolate the lowest set bit: lowest-index starving requester wins.
    assign forced_gnt = forced & (~forced + NUM_REQ'(1));

    always_comb begin
        gnt = '0;
        if (rst) begin
            gnt = '0;
        end else if (|forced) begin
            gnt = forced_gnt;
        end else if ((PRIO0 != 0) && req[0]) begin
            gnt = NUM_REQ'(1);
        end else begin
            gnt = rr_gnt;
        end
    end

    always_comb begin
        gnt_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id   = ID_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign gnt_any = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Address holds its last value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (gnt_any) begin
            mem_addr <= sel_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign rsp_valid = tag_v[ROM_LAT];
    assign rsp_id    = tag_v[ROM_LAT] ? tag_id[ROM_LAT] : '0;
    assign rsp_data  = tag_v[ROM_LAT] ? mem_data : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter
module tb_rom_port_arbiter;
    import display_pkg::*;

    localparam int AW = ROM_ADDR_W;
    localparam int DW = PIX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // A: 4 requesters, requester 0 priority
    logic [3:0]      req_a = '0;
    logic [4*AW-1:0] addr_a = '0;
    logic [3:0]      gnt_a;
    logic [AW-1:0]   mem_addr_a;
    logic [DW-1:0]   mem_data_a = '0;
    logic            rsp_valid_a;
    logic [1:0]      rsp_id_a;
    logic [DW-1:0]   rsp_data_a;

    // B: 4 requesters, plain round-robin
    logic [3:0]      req_b = '0;
    logic [4*AW-1:0] addr_b = '0;
    logic [3:0]      gnt_b;
    logic [AW-1:0]   mem_addr_b;
    logic [DW-1:0]   mem_data_b = '0;
    logic            rsp_valid_b;
    logic [1:0]      rsp_id_b;
    logic [DW-1:0]   rsp_data_b;

    // C: 3 requesters, plain round-robin
    logic [2:0]      req_c = '0;
    logic [3*AW-1:0] addr_c = '0;
    logic [2:0]      gnt_c;
    logic [AW-1:0]   mem_addr_c;
    logic [DW-1:0]   mem_data_c = '0;
    logic            rsp_valid_c;
    logic [1:0]      rsp_id_c;
    logic [DW-1:0]   rsp_data_c;

    rom_port_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(1), .MAX_WAIT(7)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .gnt(gnt_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_data(rsp_data_a));

    rom_port_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(0), .MAX_WAIT(7)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .gnt(gnt_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b));

    rom_port_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(0), .MAX_WAIT(7)) u_dut_c (
        .clk(clk), .rst(rst), .req(req_c), .req_addr(addr_c), .gnt(gnt_c), .mem_addr(mem_addr_c),
        .mem_data(mem_data_c), .rsp_valid(rsp_valid_c), .rsp_id(rsp_id_c), .rsp_data(rsp_data_c));

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[11:0] ^ {5'h0, a[18:12]} ^ 12'h3c5;
    endfunction

    // One-cycle registered ROM per instance
    always @(posedge clk) begin
        mem_data_a <= rom_fn(mem_addr_a);
        mem_data_b <= rom_fn(mem_addr_b);
        mem_data_c <= rom_fn(mem_addr_c);
    end

    // Pops the scoreboards: a response is required exactly at its due cycle, none otherwise.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                logic          v;
                int            id;
                logic [DW-1:0] d;
                int            n;
                exp_t          e;
                e = '{due: -1, id: 0, data: '0};
                case (s)
                    0: begin v = rsp_valid_a; id = int'(rsp_id_a); d = rsp_data_a; n = qa.size(); if (n > 0) e = qa[0]; end
                    1: begin v = rsp_valid_b; id = int'(rsp_id_b); d = rsp_data_b; n = qb.size(); if (n > 0) e = qb[0]; end
                    default: begin v = rsp_valid_c; id = int'(rsp_id_c); d = rsp_data_c; n = qc.size(); if (n > 0) e = qc[0]; end
                endcase
                total++;
                if (n > 0 && e.due <= cyc) begin
                    if (v !== 1'b1 || id != e.id || d !== e.data || e.due != cyc) begin
                        bad++;
                        $display("FAIL rsp inst=%0d cyc=%0d got v=%b id=%0d data=%h want v=1 id=%0d data=%h due=%0d",
                                 s, cyc, v, id, d, e.id, e.data, e.due);
                    end
                    case (s)
                        0: void'(qa.pop_front());
                        1: void'(qb.pop_front());
                        default: void'(qc.pop_front());
                    endcase
                end else if (v !== 1'b0 || d !== '0) begin
                    bad++;
                    $display("FAIL rsp_idle inst=%0d cyc=%0d got v=%b data=%h want v=0 data=0", s, cyc, v, d);
                end
            end
        end
    endtask

    // Drive one cycle on instance sel, check the grant, push the expected response.
    task automatic step(input int sel, input logic [3:0] r, input int exp_id);
        logic [4*AW-1:0] ad;
        logic [3:0]      g;
        logic [3:0]      eg;
        exp_t            e;
        for (int i = 0; i < 4; i++) ad[i*AW +: AW] = AW'($urandom);
        eg = (exp_id < 0) ? 4'b0 : 4'(1 << exp_id);
        case (sel)
            0: begin req_a = r; addr_a = ad; end
            1: begin req_b = r; addr_b = ad; end
            default: begin req_c = r[2:0]; addr_c = ad[3*AW-1:0]; end
        endcase
        @(negedge clk);
        case (sel)
            0: g = gnt_a;
            1: g = gnt_b;
            default: g = {1'b0, gnt_c};
        endcase
        total++;
        if (g !== eg) begin
            bad++;
            $display("FAIL gnt inst=%0d cyc=%0d got=%b want=%b", sel, cyc, g, eg);
        end
        if (exp_id >= 0) begin
            e.due  = cyc + 2;
            e.id   = exp_id;
            e.data = rom_fn(ad[exp_id*AW +: AW]);
            case (sel)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        req_a = '0; req_b = '0; req_c = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req_a = 4'hf;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (gnt_a !== 4'b0 || mem_addr_a !== '0 || rsp_valid_a !== 1'b0 || rsp_id_a !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b addr=%h v=%b id=%0d want 0 0 0 0", gnt_a, mem_addr_a, rsp_valid_a, rsp_id_a);
        end
        total++;
        if (gnt_b !== 4'b0 || mem_addr_b !== '0 || gnt_c !== 3'b0 || rsp_valid_c !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_bc got gnt_b=%b addr_b=%h gnt_c=%b v_c=%b want all 0", gnt_b, mem_addr_b, gnt_c, rsp_valid_c);
        end
        @(posedge clk); #1;
        req_a = '0;
        rst   = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        apply_reset();
        req_a = 4'b0001;
        for (int i = 0; i < 4; i++) addr_a[i*AW +: AW] = AW'($urandom);
        addr_a[AW-1:0] = 19'h00100;
        @(negedge clk);
        total++;
        if (gnt_a !== 4'b0001) begin
            bad++;
            $display("FAIL single_gnt got=%b want=0001", gnt_a);
        end
        e.due = cyc + 2; e.id = 0; e.data = rom_fn(19'h00100);
        qa.push_back(e);
        @(posedge clk); #1;
        req_a = '0;
        @(negedge clk);
        total++;
        if (mem_addr_a !== 19'h00100 || gnt_a !== 4'b0) begin
            bad++;
            $display("FAIL single_addr got addr=%h gnt=%b want addr=00100 gnt=0000", mem_addr_a, gnt_a);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'd0 || mem_addr_a !== 19'h00100) begin
            bad++;
            $display("FAIL single_rsp got v=%b id=%0d addr=%h want v=1 id=0 addr=00100", rsp_valid_a, rsp_id_a, mem_addr_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < 8; k++) step(1, 4'b1111, k % 4);
        step(1, 4'b1010, 1);
        step(1, 4'b1010, 3);
        step(1, 4'b1010, 1);
        step(1, 4'b0000, -1);
    endtask

    task automatic test_forced();
        apply_reset();
        for (int k = 0; k < 7; k++) step(0, 4'b0101, 0);
        step(0, 4'b0101, 2);
        step(0, 4'b0101, 0);
        step(0, 4'b0101, 0);
        step(0, 4'b0000, -1);
    endtask

    task automatic test_pulse();
        apply_reset();
        step(0, 4'b0011, 0);
        for (int k = 0; k < 3; k++) step(0, 4'b0001, 0);
        for (int k = 0; k < 7; k++) step(0, 4'b0011, 0);
        step(0, 4'b0011, 1);
        step(0, 4'b0001, 0);
        step(0, 4'b0000, -1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(0, 4'b0100, 2);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        total++;
        if (gnt_a !== 4'b0) begin
            bad++;
            $display("FAIL rst_gnt got=%b want=0000", gnt_a);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rsp_valid_a !== 1'b0 || rsp_id_a !== 2'd0 || mem_addr_a !== '0 || rsp_data_a !== '0 || gnt_a !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid got v=%b id=%0d addr=%h data=%h gnt=%b want all 0",
                     rsp_valid_a, rsp_id_a, mem_addr_a, rsp_data_a, gnt_a);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        req_a = '0;
        repeat (3) step(0, 4'b0000, -1);
    endtask

    task automatic test_nonpow2();
        apply_reset();
        for (int k = 0; k < 6; k++) step(2, 4'b0111, k % 3);
        step(2, 4'b0100, 2);
        step(2, 4'b0101, 0);
        step(2, 4'b0110, 1);
        step(2, 4'b0000, -1);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_forced();
        test_pulse();
        test_reset_mid();
        test_nonpow2();
        req_a = '0; req_b = '0; req_c = '0;
        repeat (4) @(posedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            bad++;
            $display("FAIL drain got pending a=%0d b=%0d c=%0d want 0", qa.size(), qb.size(), qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
